// File: rtl/opcodes_pkg.sv
// opcodes_pkg: decoded RV32I instruction enum shared by decode-stage blocks
package opcodes_pkg;
  typedef enum logic [5:0] {
    INVALID, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
    SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } opcode_out_t;
endpackage

// File: rtl/immediate_generator.sv
// immediate_generator: RV32I decode-stage immediate (imm_out combinational, imm_q registered; ports clk, rst_n, opcode_in, instr_in, imm_out, imm_q)
module immediate_generator
  import opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  opcode_out_t     opcode_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] imm_q
);
  always_comb begin
    imm_out = '0;
    case (opcode_in)
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, LB, LH, LW, LBU, LHU, JALR:
        imm_out = {{20{instr_in[31]}}, instr_in[31:20]};
      SLLI, SRLI, SRAI:
        imm_out = {27'b0, instr_in[24:20]};
      SB, SH, SW:
        imm_out = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      BEQ, BNE, BLT, BGE, BLTU, BGEU:
        imm_out = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      LUI, AUIPC:
        imm_out = {instr_in[31:12], 12'b0};
      JAL:
        imm_out = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      default:
        imm_out = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) imm_q <= '0;
    else imm_q <= imm_out;
endmodule

// File: tb/tb_immediate_generator.sv
// tb_immediate_generator: random and directed checks of immediate_generator against a field-arithmetic model
module tb_immediate_generator;
  import opcodes_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  opcode_out_t opc = ADDI;
  logic [31:0] instr = 32'h0;
  logic [31:0] imm_out, imm_q;
  int total = 0;
  int bad = 0;
  immediate_generator #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_in(opc), .instr_in(instr),
    .imm_out(imm_out), .imm_q(imm_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_imm(opcode_out_t op, logic [31:0] i);
    int si = int'(i);
    int sg = si >>> 31;
    if (op inside {ADDI, SLTI, SLTIU, XORI, ORI, ANDI, LB, LH, LW, LBU, LHU, JALR})
      return si >>> 20;
    if (op inside {SLLI, SRLI, SRAI})
      return (i >> 20) % 32;
    if (op inside {SB, SH, SW})
      return (si >>> 25) * 32 + int'(i[11:7]);
    if (op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU})
      return sg * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    if (op inside {LUI, AUIPC})
      return (i / 4096) * 4096;
    if (op == JAL)
      return sg * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    return 32'h0;
  endfunction
  initial begin
    logic [31:0] exp;
    #3;
    chk("reset_q", imm_q, 32'h0);
    opc = ADDI; instr = 32'hFFF30293; #1; chk("addi", imm_out, 32'hFFFFFFFF);
    opc = SW;   instr = 32'hFE20AE23; #1; chk("sw", imm_out, 32'hFFFFFFFC);
    opc = BEQ;  instr = 32'hFE008CE3; #1; chk("beq", imm_out, 32'hFFFFFFF8);
    opc = LUI;  instr = 32'hABCDE0B7; #1; chk("lui", imm_out, 32'hABCDE000);
    opc = JAL;  instr = 32'hFEDFF0EF; #1; chk("jal", imm_out, 32'hFFFFFFEC);
    opc = EBREAK; instr = 32'hFFFFFFFF; #1; chk("ebreak_zero", imm_out, 32'h0);
    opc = ADDI; instr = 32'h00000033; #1; chk("opc_wins", imm_out, 32'h0);
    chk("reset_hold_q", imm_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    opc = SRAI; instr = 32'h40535293; #1;
    chk("srai", imm_out, 32'h5);
    @(posedge clk); #1;
    chk("srai_q", imm_q, 32'h5);
    opc = ADD; #1;
    chk("add_zero", imm_out, 32'h0);
    chk("q_holds", imm_q, 32'h5);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      opc = opcode_out_t'($urandom_range(0, 40));
      instr = $urandom;
      exp = ref_imm(opc, instr);
      #1;
      chk($sformatf("rnd_comb_%0s", opc.name()), imm_out, exp);
      @(posedge clk); #1;
      chk("rnd_q", imm_q, exp);
      if (n == 150) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset_q", imm_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        opc = JAL; instr = 32'h80000000;
        #1 chk("q_after_release_before_edge", imm_q, 32'h0);
        @(posedge clk); #1;
        chk("q_first_edge_after_release", imm_q, 32'hFFF00000);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
